uart_tx: RTL and testbench

Transmit half of the board's USB-serial UART link: accepts bytes from on-chip logic through a valid/ready handshake, buffers them in a small FIFO, and serialises each as an 8N1 frame (start bit, 8 data bits LSB first, stop bit) on the TXD pin. It pairs with the existing `uart_rx` on the same PMOD. Optional hardware flow control gates new frames on the host's CTS#.

---
 rtl/uart_tx.sv | 191 +++++++++++++++++++
 tb/tb_uart_tx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// uart_tx -- 8N1 UART transmitter with a small byte FIFO.
//
// Bytes enter through a valid/ready handshake, queue in a FIFO of
// FIFO_DEPTH entries, and are serialised on tx as start bit, 8 data bits
// LSB first, stop bit. Each bit lasts CLKS_PER_BIT clocks. Back-to-back
// frames run with no idle gap.
//
// Optional feature macro: UART_TX_CTS_EN
//   defined   : a new frame starts only while cts (active-low CTS#) is 0.
//               cts is sampled only when a pop decision is made.
//   undefined : cts is ignored. The port remains for pin compatibility.
//
// Ports
//   clk      in   system clock, rising edge
//   reset    in   synchronous reset, active low
//   data_in  in   [7:0] byte to send
//   valid    in   data_in offered this cycle
//   ready    out  FIFO not full; a push is accepted when valid && ready
//   cts      in   host clear-to-send, active low
//   tx       out  serial data, idle high, registered
//   busy     out  frame in progress or FIFO non-empty
//   debug    out  [7:0] last byte loaded into the shifter
module uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 104,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       valid,
    output logic       ready,
    input  logic       cts,
    output logic       tx,
    output logic       busy,
    output logic [7:0] debug
);

    localparam int unsigned PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [PTR_W:0]    CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    state_t            r_state;
    logic [BAUD_W-1:0] r_baud;
    logic [2:0]        r_bit_idx;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic [7:0]        r_debug;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W:0]    r_count;

    logic              w_ready;
    logic              w_push;
    logic              w_pop;
    logic              w_gate;
    logic              w_baud_end;
    logic              w_decide;
    logic [7:0]        w_head;

`ifdef UART_TX_CTS_EN
    assign w_gate = ~cts;
`else
    logic w_unused_cts;
    assign w_unused_cts = cts;
    assign w_gate       = 1'b1;
`endif

    assign w_ready    = (r_count != CNT_FULL);
    assign w_push     = valid && w_ready;
    assign w_baud_end = (r_baud == BAUD_LAST);
    // Pop decisions happen in IDLE and on the last cycle of the stop bit,
    // which is what lets the next start bit follow with no gap.
    assign w_decide   = (r_state == S_IDLE) || ((r_state == S_STOP) && w_baud_end);
    assign w_pop      = w_decide && (r_count != '0) && w_gate;
    assign w_head     = r_mem[r_rd_ptr];

    // FIFO storage: contents need no reset, the pointers define validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Transmit FSM. tx is updated on each transition so that it already
    // holds the level of the state being entered.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_baud    <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_tx      <= 1'b1;
            r_debug   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_baud <= '0;
                    if (w_pop) begin
                        r_shift <= w_head;
                        r_debug <= w_head;
                        r_tx    <= 1'b0;
                        r_state <= S_START;
                    end
                end
                S_START: begin
                    if (w_baud_end) begin
                        r_baud    <= '0;
                        r_bit_idx <= '0;
                        r_tx      <= r_shift[0];
                        r_state   <= S_DATA;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_baud_end) begin
                        r_baud  <= '0;
                        r_shift <= {1'b0, r_shift[7:1]};
                        if (r_bit_idx == 3'd7) begin
                            r_tx    <= 1'b1;
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                            // The next bit is shift[1] before the shift lands.
                            r_tx      <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                S_STOP: begin
                    if (w_baud_end) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_head;
                            r_debug <= w_head;
                            r_tx    <= 1'b0;
                            r_state <= S_START;
                        end else begin
                            r_tx    <= 1'b1;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_baud  <= '0;
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign ready = w_ready;
    assign tx    = r_tx;
    assign debug = r_debug;
    assign busy  = (r_state != S_IDLE) || (r_count != '0);

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// Stimulus pushes the expected byte of every accepted write into exp_q.
// A monitor decodes frames on tx and compares each one against the head
// of exp_q. Directed checks cover reset, latency, timing and FIFO limits.
module tb_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] data_in;
    logic       valid;
    logic       ready;
    logic       cts;
    logic       tx;
    logic       busy;
    logic [7:0] debug;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];
    int         start_q[$];

    uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .data_in(data_in),
        .valid  (valid),
        .ready  (ready),
        .cts    (cts),
        .tx     (tx),
        .busy   (busy),
        .debug  (debug)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Call at #1 after an edge; returns at #1 after edge c.
    task automatic wait_until(input int c);
        int n;
        n = c - cyc;
        if (n < 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_until: target %0d already passed at %0d", c, cyc);
            n = 0;
        end
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Frame monitor: one sample per clock on the falling edge. Every sample
    // within a bit must match the first, so a glitch is caught too.
    int         mon_k = -1;
    logic [9:0] mon_bits;
    logic       mon_glitch;
    logic [7:0] mon_exp;

    always @(negedge clk) begin
        if (reset !== 1'b1) begin
            mon_k = -1;
        end else if (mon_k < 0 && tx === 1'b0) begin
            mon_k      = 0;
            mon_glitch = 1'b0;
            start_q.push_back(cyc);
        end
        if (mon_k >= 0) begin
            if (mon_k % CPB == 0) mon_bits[mon_k / CPB] = tx;
            else if (tx !== mon_bits[mon_k / CPB]) mon_glitch = 1'b1;
            mon_k++;
            if (mon_k == 10 * CPB) begin
                mon_k = -1;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL frame: got unexpected frame bits %b expected no frame", mon_bits);
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_bits[0] !== 1'b0 || mon_bits[9] !== 1'b1 ||
                        mon_bits[8:1] !== mon_exp || mon_glitch) begin
                        n_fail++;
                        $display("FAIL frame: got bits %b glitch %0b expected byte %02h framed 1..0",
                                 mon_bits, mon_glitch, mon_exp);
                    end
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b2b [5];
        logic       rdy_exp [5];
        int n;
        int m;

        b2b     = '{8'hA3, 8'h0F, 8'hFF, 8'h00, 8'h81};
        rdy_exp = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

        reset   = 1'b0;
        valid   = 1'b0;
        data_in = 8'h00;
        cts     = 1'b0;

        // Reset
        repeat (3) @(posedge clk);
        #1;
        chk("reset tx", tx, 1);
        chk("reset ready", ready, 1);
        chk("reset busy", busy, 0);
        chk("reset debug", debug, 8'h00);
        reset = 1'b1;
        wait_until(cyc + 10);
        chk("idle tx", tx, 1);
        chk("idle busy", busy, 0);
        chk("idle no frame", start_q.size(), 0);

        // Single byte
        start_q.delete();
        data_in = 8'h55;
        valid   = 1'b1;
        exp_q.push_back(8'h55);
        @(posedge clk);
        #1;
        valid = 1'b0;
        n = cyc;
        chk("single tx before pop", tx, 1);
        chk("single busy", busy, 1);
        wait_until(n + 1);
        chk("single start bit", tx, 0);
        chk("single debug", debug, 8'h55);
        wait_until(n + 40);
        chk("single stop bit", tx, 1);
        chk("single busy at N+40", busy, 1);
        wait_until(n + 41);
        chk("single busy falls", busy, 0);
        wait_until(n + 43);
        chk("single frames", start_q.size(), 1);
        if (start_q.size() > 0) chk("single start cycle", start_q[0], n + 1);

        // Back-to-back and full, then overflow
        start_q.delete();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            data_in = b2b[i];
            valid   = 1'b1;
            exp_q.push_back(b2b[i]);
            @(posedge clk);
            #1;
            if (i == 0) n = cyc;
            chk($sformatf("b2b ready after push %0d", i), ready, rdy_exp[i]);
        end
        data_in = 8'h77;
        @(posedge clk);
        #1;
        valid = 1'b0;
        chk("overflow ready", ready, 0);
        chk("overflow debug", debug, 8'hA3);
        wait_until(n + 40);
        chk("full ready before pop", ready, 0);
        wait_until(n + 41);
        chk("ready after pop", ready, 1);
        chk("second byte debug", debug, 8'h0F);
        wait_until(n + 200);
        chk("b2b busy last cycle", busy, 1);
        wait_until(n + 201);
        chk("b2b busy falls", busy, 0);
        wait_until(n + 210);
        chk("b2b frames", start_q.size(), 5);
        for (int i = 0; i < 5; i++)
            if (i < start_q.size()) chk($sformatf("b2b start %0d", i), start_q[i], n + 1 + 40 * i);
        chk("b2b all bytes received", exp_q.size(), 0);

`ifdef UART_TX_CTS_EN
        // Flow control
        start_q.delete();
        cts     = 1'b1;
        data_in = 8'h42;
        valid   = 1'b1;
        exp_q.push_back(8'h42);
        @(posedge clk);
        #1;
        valid = 1'b0;
        n = cyc;
        wait_until(n + 20);
        chk("cts hold tx", tx, 1);
        chk("cts hold busy", busy, 1);
        chk("cts hold no frame", start_q.size(), 0);
        cts = 1'b0;
        m = cyc;
        wait_until(m + 1);
        chk("cts start bit", tx, 0);
        wait_until(m + 15);
        cts = 1'b1;
        wait_until(m + 41);
        chk("cts busy falls", busy, 0);
        chk("cts frames", start_q.size(), 1);
        if (start_q.size() > 0) chk("cts start cycle", start_q[0], m + 1);
        cts = 1'b0;
`endif

        // Reset mid-frame
        start_q.delete();
        valid = 1'b1;
        n = 0;
        for (int i = 0; i < 3; i++) begin
            data_in = (i == 0) ? 8'hC6 : ((i == 1) ? 8'h11 : 8'h22);
            exp_q.push_back(data_in);
            @(posedge clk);
            #1;
            if (i == 0) n = cyc;
        end
        valid = 1'b0;
        wait_until(n + 18);
        chk("midframe data bit 3", tx, 0);
        reset = 1'b0;
        wait_until(n + 19);
        chk("midframe reset tx", tx, 1);
        chk("midframe reset ready", ready, 1);
        chk("midframe reset busy", busy, 0);
        chk("midframe reset debug", debug, 8'h00);
        wait_until(n + 20);
        reset = 1'b1;
        exp_q.delete();
        start_q.delete();
        wait_until(n + 80);
        chk("post reset no frame", start_q.size(), 0);
        chk("post reset busy", busy, 0);
        chk("post reset tx", tx, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
